// File: rtl/seq_multiplier32.sv
// Unsigned 32x32->64 shift-add multiplier built around one 32-bit ripple adder.
// One operation in flight; valid/ready handshake on both operand and product sides.

module adder32bit (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        cin_i,
    output logic [31:0] res_o,
    output logic        cout_o
);
    assign {cout_o, res_o} = {1'b0, a_i} + {1'b0, b_i} + {32'd0, cin_i};
endmodule

module seq_multiplier32 #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t                state_q;
    logic [WIDTH-1:0]      m_q;
    logic [WIDTH-1:0]      acc_q;
    logic [WIDTH-1:0]      q_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [2*WIDTH-1:0]    product_q;
    logic                  out_valid_q;

    logic [WIDTH-1:0]      addend_s;
    logic [WIDTH-1:0]      sum_s;
    logic                  cout_s;

    assign addend_s = q_q[0] ? m_q : {WIDTH{1'b0}};

    adder32bit u_adder (
        .a_i    (acc_q),
        .b_i    (addend_s),
        .cin_i  (1'b0),
        .res_o  (sum_s),
        .cout_o (cout_s)
    );

    assign in_ready  = (state_q == IDLE) && rst_n;
    assign out_valid = out_valid_q;
    assign product   = product_q;

    // Multiplier FSM: operand capture, one shift-add iteration per cycle, product hold.
    // The carry bit C is consumed in the same edge it is produced; after the right
    // shift it is always zero, so it is never stored as a separate register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            m_q         <= {WIDTH{1'b0}};
            acc_q       <= {WIDTH{1'b0}};
            q_q         <= {WIDTH{1'b0}};
            cnt_q       <= {CNT_W{1'b0}};
            product_q   <= {(2*WIDTH){1'b0}};
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        m_q     <= a;
                        q_q     <= b;
                        acc_q   <= {WIDTH{1'b0}};
                        cnt_q   <= {CNT_W{1'b0}};
                        state_q <= CALC;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                CALC: begin
                    acc_q <= {cout_s, sum_s[WIDTH-1:1]};
                    q_q   <= {sum_s[0], q_q[WIDTH-1:1]};
                    cnt_q <= cnt_q + CNT_ONE;
                    if (cnt_q == CNT_LAST) begin
                        product_q   <= {cout_s, sum_s, q_q[WIDTH-1:1]};
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        state_q <= CALC;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end else begin
                        state_q <= DONE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_seq_multiplier32.sv
// Directed and random checks of seq_multiplier32: latency, results, hold, abort, throughput.

module tb_seq_multiplier32;
    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] product;

    int errors = 0;
    int checks = 0;

    seq_multiplier32 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation; lat = edges from acceptance until out_valid seen, -1 on timeout.
    task automatic run_op(input logic [31:0] av, input logic [31:0] bv, input bit hold,
                          output logic [63:0] prod, output int lat);
        int waited = 0;
        while (!in_ready && waited < 100) begin
            tick();
            waited++;
        end
        a = av;
        b = bv;
        in_valid = 1'b1;
        tick();
        if (hold) begin
            a = $urandom;
            b = $urandom;
        end else begin
            in_valid = 1'b0;
            a = 32'hA5A5_A5A5;
            b = 32'h5A5A_5A5A;
        end
        lat = 0;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
        if (!out_valid) lat = -1;
        prod = product;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        a = 32'd0;
        b = 32'd0;
        tick();
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid got=%b exp=0", out_valid);
        end
        checks++;
        if (product !== 64'd0) begin
            errors++;
            $display("FAIL reset_product got=%h exp=0", product);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_ready_low got=%b exp=0", in_ready);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready_idle got=%b exp=1", in_ready);
        end
    endtask

    task automatic test_basic();
        logic [63:0] p;
        int lat;
        out_ready = 1'b1;
        run_op(32'd3, 32'd5, 1'b0, p, lat);
        checks++;
        if (lat !== 32) begin
            errors++;
            $display("FAIL basic_latency got=%0d exp=32", lat);
        end
        checks++;
        if (p !== 64'h0F) begin
            errors++;
            $display("FAIL basic_3x5 got=%h exp=000000000000000f", p);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_handshake got valid=%b ready=%b exp valid=0 ready=1",
                     out_valid, in_ready);
        end
    endtask

    task automatic test_corners();
        logic [31:0] av [4] = '{32'hFFFF_FFFF, 32'd0,       32'd1,       32'h8000_0000};
        logic [31:0] bv [4] = '{32'hFFFF_FFFF, 32'hDEADBEEF, 32'hDEADBEEF, 32'd2};
        logic [63:0] ev [4] = '{64'hFFFF_FFFE_0000_0001, 64'd0, 64'h0000_0000_DEAD_BEEF,
                                64'h0000_0001_0000_0000};
        logic [63:0] p;
        int lat;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            run_op(av[i], bv[i], 1'b0, p, lat);
            checks++;
            if (lat !== 32 || p !== ev[i]) begin
                errors++;
                $display("FAIL corner_%0d got=%h lat=%0d exp=%h lat=32", i, p, lat, ev[i]);
            end
            tick();
        end
    endtask

    task automatic test_hold();
        logic [63:0] p;
        int lat;
        int bad = 0;
        out_ready = 1'b0;
        run_op(32'd7, 32'd9, 1'b0, p, lat);
        checks++;
        if (lat !== 32 || p !== 64'h3F) begin
            errors++;
            $display("FAIL hold_result got=%h lat=%0d exp=3f lat=32", p, lat);
        end
        a = 32'd100;
        b = 32'd100;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out_valid !== 1'b1 || product !== 64'h3F || in_ready !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL hold_stable bad_cycles=%0d exp=0", bad);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || product !== 64'h3F) begin
            errors++;
            $display("FAIL hold_release got valid=%b ready=%b prod=%h exp 0/1/3f",
                     out_valid, in_ready, product);
        end
        // A stray acceptance during DONE would leave the block busy now.
        tick();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL hold_ignored_valid got ready=%b exp=1", in_ready);
        end
    endtask

    task automatic test_abort();
        logic [63:0] p;
        int lat;
        int seen = 0;
        out_ready = 1'b1;
        a = 32'd1234;
        b = 32'd5678;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || product !== 64'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_state got valid=%b prod=%h ready=%b exp 0/0/1",
                     out_valid, product, in_ready);
        end
        for (int i = 0; i < 40; i++) begin
            tick();
            if (out_valid) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL abort_no_output valid_cycles=%0d exp=0", seen);
        end
        run_op(32'd6, 32'd7, 1'b0, p, lat);
        checks++;
        if (lat !== 32 || p !== 64'h2A) begin
            errors++;
            $display("FAIL abort_next_op got=%h lat=%0d exp=2a lat=32", p, lat);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] av;
        logic [31:0] bv;
        logic [63:0] p;
        logic [63:0] ref_p;
        int lat;
        out_ready = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            av = $urandom;
            bv = $urandom;
            ref_p = 64'(av) * 64'(bv);
            run_op(av, bv, 1'b1, p, lat);
            checks++;
            if (lat !== 32 || p !== ref_p) begin
                errors++;
                $display("FAIL b2b_%0d a=%h b=%h got=%h lat=%0d exp=%h lat=32",
                         i, av, bv, p, lat, ref_p);
            end
            tick();
            checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL b2b_ready_%0d got ready=%b valid=%b exp 1/0",
                         i, in_ready, out_valid);
            end
        end
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_corners();
        test_hold();
        test_abort();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
